window_gen_3x3: RTL and testbench
=================================

// Module: window_gen_3x3
// PURPOSE
//  Streaming 3x3 sliding-window generator. Sits directly upstream of conv_core.
//  Accepts a raster-order pixel stream (Q1.6, one pixel per accepted beat) and buffers two
//  image lines, emitting a registered matrix_3x3 window for every valid
//  (no-padding, stride-1) kernel position. The window feeds conv_core.input_data.
// PARAMETERS
//  IMG_W   8   image width in pixels (>=3); sets line-buffer depth and column counter range
//  IMG_H   8   image height in lines (>=3); sets row counter range
// PORTS
//  clk_i           in   1      clock; all state updates on rising edge
//  rst_i           in   1      synchronous reset, active-high
//  pix_valid_i     in   1      pixel_i valid this cycle; beat accepted when high (no backpressure)
//  pixel_i         in   8      pixel, Q1.6 two's complement (same element type as matrix_3x3)
//  window_o        out  9x8    matrix_3x3; vectorK = image row r-2+K, pJ = column c-2+J
//  window_valid_o  out  1      window_o holds a new valid window this cycle (1-cycle pulse/beat)
//  win_row_o       out  clog2(IMG_H)  row index r of window's bottom-right pixel
//  win_col_o       out  clog2(IMG_W)  column index c of window's bottom-right pixel
//  frame_done_o    out  1      1-cycle pulse, cycle after last pixel (IMG_H-1,IMG_W-1) accepted
// BEHAVIOUR
//  Reset (rst_i=1 at edge): col/row counters=0, state=S_FILL, window_o=0, window_valid_o=0,
//   win_row_o=0, win_col_o=0, frame_done_o=0. Line-buffer RAM is not cleared.
//   Reset has priority over an accepted beat in the same cycle. Mid-frame reset aborts the frame.
//   The next accepted pixel is (0,0).
//  Storage: lb0[IMG_W] (previous line), lb1[IMG_W] (line before that), 3x3 window register.
//  On accepted beat, pixel P at (r,c):
//   - new column {top,mid,bot} = {lb1[c], lb0[c], P}; lb1[c]<=lb0[c]; lb0[c]<=P
//   - window shifts left: pJ<=p(J+1) for J=0,1; p2<=new column (vector0=top, vector2=bot)
//   - c increments; at c=IMG_W-1, c wraps to 0 and r increments
//   - at (IMG_H-1,IMG_W-1), r wraps to 0 and frame_done_o pulses next cycle
//  Output timing: latency 1 cycle. window_valid_o=1 in the cycle after accepting P
//   iff r>=2 and c>=2. window_o then = pixels (r-2..r, c-2..c). win_row_o=r, win_col_o=c.
//  Cycles without a beat: window_valid_o=0. window_o, win_* and counters hold. Gaps are allowed anywhere.
//  Column wrap: windows at c=0,1 are never flagged valid, because the shift register spans
//   lines. Exactly (IMG_W-2)*(IMG_H-2) valid windows are emitted per frame.
//  FSM: S_FILL (r<2, no valid output) -> S_RUN on accepting (1,IMG_W-1);
//   S_RUN -> S_FILL on accepting (IMG_H-1,IMG_W-1). rst_i -> S_FILL from any state.
//  Back-to-back frames: pixel (0,0) of the next frame may be accepted the cycle after the
//   previous frame's last pixel. No dead cycle. Stale line-buffer data is never exposed,
//   because rows 0-1 are rewritten before any valid window.
//  Arithmetic: pixels are passed through bit-exact; no sign extension, rounding or saturation.
//  Counters are sized clog2(IMG_W)/clog2(IMG_H). Compares use IMG_W-1/IMG_H-1 explicitly
//   (non-power-of-2 sizes are legal).
// TESTING (IMG_W=4, IMG_H=4 unless noted; pixel value = raster index 0..15)
//  1. Continuous stream 0..15 -> cycle after pixel 10 accepted: window_valid_o=1, vector0={0,1,2},
//     vector1={4,5,6}, vector2={8,9,10}, win_row_o=2, win_col_o=2. Next windows follow
//     pixels 11, 14, 15 (last = {5,6,7},{9,10,11},{13,14,15}). Exactly 4 valid pulses.
//     frame_done_o pulses once, after pixel 15.
//  2. Same stream with random pix_valid_i gaps -> identical window sequence and values.
//     window_valid_o is never high in a cycle not following an accepted beat.
//  3. Two frames back-to-back (second frame = index+16) -> no valid window during second-frame
//     rows 0-1. First valid window of frame 2 is {16,17,18},{20,21,22},{24,25,26}.
//  4. rst_i asserted after pixel 9, then restart from 0 -> no window_valid_o until new pixel 10.
//     That window equals test 1's first window. Reset coincident with a beat -> beat dropped.
//  5. Sign/extremes: pixels 8'h80, 8'h7F, 8'hFF interleaved -> window_o bits match inputs exactly.
//  6. IMG_W=5, IMG_H=3 -> 3 valid windows (win_col_o=2,3,4, win_row_o=2). Counter wrap is correct
//     for non-power-of-2 width.

Source files
------------

// File: rtl/window_gen_3x3_if.sv
// rtl/window_gen_3x3_if.sv - pixel stream in / 3x3 window out bundle for window_gen_3x3
interface window_gen_3x3_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic                   pix_valid_i;
    logic [7:0]             pixel_i;
    logic [2:0][2:0][7:0]   window_o;
    logic                   window_valid_o;
    logic [RW-1:0]          win_row_o;
    logic [CW-1:0]          win_col_o;
    logic                   frame_done_o;

    modport slave (
        input  pix_valid_i, pixel_i,
        output window_o, window_valid_o, win_row_o, win_col_o, frame_done_o
    );

    modport master (
        output pix_valid_i, pixel_i,
        input  window_o, window_valid_o, win_row_o, win_col_o, frame_done_o
    );
endinterface

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 sliding-window generator with two line buffers
module window_gen_3x3 #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    window_gen_3x3_if.slave  s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [2:0][2:0][7:0]   win_q, win_d;
    logic                   win_valid_q, win_valid_d;
    logic [RW-1:0]          win_row_q, win_row_d;
    logic [CW-1:0]          win_col_q, win_col_d;
    logic                   frame_done_q, frame_done_d;

    logic [7:0]             lb0_q [IMG_W];
    logic [7:0]             lb1_q [IMG_W];

    logic                   beat;
    logic                   last_col;
    logic                   last_row;

    assign beat     = s.pix_valid_i && !rst_i;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    // Line buffers carry no reset; rows 0-1 of every frame overwrite them before use.
    always_ff @(posedge clk_i) begin
        if (beat) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= s.pixel_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        if (beat) begin
            for (int k = 0; k < 3; k++) begin
                win_d[k][0] = win_q[k][1];
                win_d[k][1] = win_q[k][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = s.pixel_i;

            // In S_RUN the row is always >= 2, so only the column gates validity.
            win_valid_d = (state_q == S_RUN) && (col_q >= CW'(2));
            win_row_d   = row_q;
            win_col_d   = col_q;

            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end

            case (state_q)
                S_FILL:  if (last_col && row_q == RW'(1)) state_d = S_RUN;
                S_RUN:   if (last_col && last_row)        state_d = S_FILL;
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s.window_o       = win_q;
    assign s.window_valid_o = win_valid_q;
    assign s.win_row_o      = win_row_q;
    assign s.win_col_o      = win_col_q;
    assign s.frame_done_o   = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - scoreboard bench for window_gen_3x3 (4x4 and 5x3 instances)
module tb_window_gen_3x3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    window_gen_3x3_if #(.IMG_W(4), .IMG_H(4)) if4 ();
    window_gen_3x3_if #(.IMG_W(5), .IMG_H(3)) if5 ();

    window_gen_3x3 #(.IMG_W(4), .IMG_H(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .s(if4.slave));
    window_gen_3x3 #(.IMG_W(5), .IMG_H(3)) u_dut5 (.clk_i(clk), .rst_i(rst), .s(if5.slave));

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;

    logic [7:0] img [2][8][8];
    int mr[2] = '{0, 0};
    int mc[2] = '{0, 0};
    int W[2]  = '{4, 5};
    int H[2]  = '{4, 3};
    int vcnt[2]  = '{0, 0};
    int fdcnt[2] = '{0, 0};

    logic [1:0] pend_v   = '0;
    logic [1:0] pend_fd  = '0;
    logic [1:0] exp_v_q  = '0;
    logic [1:0] exp_fd_q = '0;

    logic [7:0] pat [3] = '{8'h80, 8'h7F, 8'hFF};

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] p);
        exp_t e;
        logic [2:0][2:0][7:0] w;
        int r;
        int c;
        if4.pix_valid_i = v && (sel == 0);
        if4.pixel_i     = p;
        if5.pix_valid_i = v && (sel == 1);
        if5.pixel_i     = p;
        pend_v  = '0;
        pend_fd = '0;
        if (v) begin
            r = mr[sel];
            c = mc[sel];
            img[sel][r][c] = p;
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 3; k++)
                    for (int j = 0; j < 3; j++)
                        w[k][j] = img[sel][r-2+k][c-2+j];
                e.win = w;
                e.row = r;
                e.col = c;
                if (sel == 0) q0.push_back(e);
                else          q1.push_back(e);
                pend_v[sel] = 1'b1;
            end
            if (c == W[sel] - 1) begin
                mc[sel] = 0;
                if (r == H[sel] - 1) begin
                    mr[sel] = 0;
                    pend_fd[sel] = 1'b1;
                end else begin
                    mr[sel] = r + 1;
                end
            end else begin
                mc[sel] = c + 1;
            end
        end
        @(posedge clk);
        #1;
        pend_v  = '0;
        pend_fd = '0;
        if4.pix_valid_i = 1'b0;
        if5.pix_valid_i = 1'b0;
    endtask

    task automatic do_reset(input logic beat);
        rst = 1'b1;
        if4.pix_valid_i = beat;
        if4.pixel_i     = 8'd99;
        if5.pix_valid_i = 1'b0;
        if5.pixel_i     = 8'd0;
        pend_v  = '0;
        pend_fd = '0;
        mr = '{0, 0};
        mc = '{0, 0};
        @(posedge clk);
        #1;
        rst = 1'b0;
        if4.pix_valid_i = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_v_q  <= pend_v;
        exp_fd_q <= pend_fd;
    end

    task automatic mon(input int sel, input logic vld, input logic [71:0] win,
                       input int row, input int col, input logic fd);
        exp_t e;
        if (vld || exp_v_q[sel])
            check($sformatf("valid%0d", sel), 72'(vld), 72'(exp_v_q[sel]));
        if (vld === 1'b1) begin
            vcnt[sel]++;
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                check($sformatf("sb_underflow%0d", sel), 72'(vld), 72'(0));
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("window%0d", sel), win, e.win);
                check($sformatf("win_row%0d", sel), 72'(row), 72'(e.row));
                check($sformatf("win_col%0d", sel), 72'(col), 72'(e.col));
            end
        end
        if (fd || exp_fd_q[sel])
            check($sformatf("frame_done%0d", sel), 72'(fd), 72'(exp_fd_q[sel]));
        if (fd === 1'b1) fdcnt[sel]++;
    endtask

    always @(negedge clk) begin
        mon(0, if4.window_valid_o, if4.window_o, int'(if4.win_row_o), int'(if4.win_col_o), if4.frame_done_o);
        mon(1, if5.window_valid_o, if5.window_o, int'(if5.win_row_o), int'(if5.win_col_o), if5.frame_done_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int f0;
        if4.pix_valid_i = 1'b0;
        if4.pixel_i     = 8'd0;
        if5.pix_valid_i = 1'b0;
        if5.pixel_i     = 8'd0;
        do_reset(1'b0);
        @(negedge clk);
        check("rst_window", if4.window_o, 72'd0);
        check("rst_valid", 72'(if4.window_valid_o), 72'd0);
        check("rst_row", 72'(if4.win_row_o), 72'd0);
        check("rst_col", 72'(if4.win_col_o), 72'd0);
        check("rst_fd", 72'(if4.frame_done_o), 72'd0);

        // continuous frame with a hand-derived first window
        v0 = vcnt[0]; f0 = fdcnt[0];
        for (int i = 0; i <= 10; i++) drive(0, 1'b1, 8'(i));
        @(negedge clk);
        check("t1_first", if4.window_o,
              {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
        check("t1_first_rc", 72'({if4.win_row_o, if4.win_col_o}), 72'({2'd2, 2'd2}));
        for (int i = 11; i <= 15; i++) drive(0, 1'b1, 8'(i));
        settle();
        check("t1_count", 72'(vcnt[0] - v0), 72'd4);
        check("t1_fd", 72'(fdcnt[0] - f0), 72'd1);

        // random gaps
        v0 = vcnt[0]; f0 = fdcnt[0];
        for (int i = 0; i <= 15; i++) begin
            while ($urandom_range(0, 2) == 0) drive(0, 1'b0, 8'($urandom));
            drive(0, 1'b1, 8'(i));
        end
        settle();
        check("t2_count", 72'(vcnt[0] - v0), 72'd4);
        check("t2_fd", 72'(fdcnt[0] - f0), 72'd1);

        // back-to-back frames
        v0 = vcnt[0]; f0 = fdcnt[0];
        for (int i = 0; i <= 31; i++) drive(0, 1'b1, 8'(i));
        settle();
        check("t3_count", 72'(vcnt[0] - v0), 72'd8);
        check("t3_fd", 72'(fdcnt[0] - f0), 72'd2);

        // mid-frame reset coincident with a beat, then restart
        for (int i = 0; i <= 9; i++) drive(0, 1'b1, 8'(i));
        v0 = vcnt[0]; f0 = fdcnt[0];
        do_reset(1'b1);
        for (int i = 0; i <= 15; i++) drive(0, 1'b1, 8'(i));
        settle();
        check("t4_count", 72'(vcnt[0] - v0), 72'd4);
        check("t4_fd", 72'(fdcnt[0] - f0), 72'd1);

        // sign extremes
        v0 = vcnt[0];
        for (int i = 0; i <= 15; i++) drive(0, 1'b1, pat[i % 3]);
        settle();
        check("t5_count", 72'(vcnt[0] - v0), 72'd4);

        // non-power-of-2 width instance
        v0 = vcnt[1]; f0 = fdcnt[1];
        for (int i = 0; i <= 14; i++) drive(1, 1'b1, 8'(i + 40));
        settle();
        check("t6_count", 72'(vcnt[1] - v0), 72'd3);
        check("t6_fd", 72'(fdcnt[1] - f0), 72'd1);

        check("sb_left0", 72'(q0.size()), 72'd0);
        check("sb_left1", 72'(q1.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
